// File: rtl/grid_accum_ctrl_pkg.sv
// grid_accum_ctrl_pkg: default grid geometry, complex word type and controller states
package grid_accum_ctrl_pkg;
  localparam int DATA_REAL_WIDTH    = 32;
  localparam int DATA_IMAG_WIDTH    = 32;
  localparam int GRID_ADDRESS_WIDTH = 4;
  localparam int DIMENSION          = 16;
  localparam int READ_LATENCY       = 2;
  typedef struct packed {
    logic [DATA_REAL_WIDTH-1:0] re;
    logic [DATA_IMAG_WIDTH-1:0] im;
  } cplx_t;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, CLEAR} accum_state_t;
endpackage

// File: rtl/grid_accum_ctrl_sat_add.sv
// sat_add: two's complement adder that clamps to the signed range instead of wrapping
module sat_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] s_o
);
  logic [W:0] s;
  assign s = {a_i[W-1], a_i} + {b_i[W-1], b_i};
  // s[W] is the true sign; disagreement with s[W-1] means overflow
  assign s_o = (s[W] != s[W-1]) ? (s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : s[W-1:0];
endmodule

// File: rtl/grid_accum_ctrl.sv
// grid_accum_ctrl: read-modify-write deposit pipeline and clear sweep for a D x D banked grid memory
module grid_accum_ctrl
  import grid_accum_ctrl_pkg::*;
#(
  parameter int DRW = DATA_REAL_WIDTH,
  parameter int DIW = DATA_IMAG_WIDTH,
  parameter int GAW = GRID_ADDRESS_WIDTH,
  parameter int D   = DIMENSION,
  parameter int RL  = READ_LATENCY,
  localparam int YW = $clog2(D),
  localparam int DW = DRW + DIW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [GAW-1:0]                in_x_i,
  input  logic [YW-1:0]                 in_y_i,
  input  logic [YW-1:0]                 in_z_i,
  input  logic [DRW-1:0]                in_real_i,
  input  logic [DIW-1:0]                in_imag_i,
  input  logic                          clear_start_i,
  output logic                          clear_done_o,
  output logic                          busy_o,
  output logic [D-1:0][D-1:0][GAW-1:0]  rd_addr_o,
  input  logic [D-1:0][D-1:0][DW-1:0]   rd_data_i,
  output logic [D-1:0][D-1:0][GAW-1:0]  wr_addr_o,
  output logic [D-1:0][D-1:0][DW-1:0]   wr_data_o,
  output logic [D-1:0][D-1:0]           wren_o
);
  localparam int DEPTH = 2 + RL;
  typedef struct packed {
    logic           v;
    logic [GAW-1:0] x;
    logic [YW-1:0]  y;
    logic [YW-1:0]  z;
    logic [DRW-1:0] re;
    logic [DIW-1:0] im;
  } ent_t;
  accum_state_t   state_q;
  ent_t           pipe_q [DEPTH];
  logic           w_v_q;
  logic [GAW-1:0] w_x_q, cnt_q, cnt_nx;
  logic [YW-1:0]  w_y_q, w_z_q;
  logic           hazard, pipe_busy, accept;
  logic [DW-1:0]  rd_word;
  logic [DRW-1:0] sum_re;
  logic [DIW-1:0] sum_im;
  ent_t           last;
  // the write stage is included so a repeat address reads only after its predecessor landed
  always_comb begin
    hazard = w_v_q && ({w_x_q, w_y_q, w_z_q} == {in_x_i, in_y_i, in_z_i});
    pipe_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hazard = hazard | (pipe_q[i].v && ({pipe_q[i].x, pipe_q[i].y, pipe_q[i].z} == {in_x_i, in_y_i, in_z_i}));
      pipe_busy = pipe_busy | pipe_q[i].v;
    end
  end
  assign in_ready_o = rst_n && (state_q == IDLE || state_q == ACCUM) && !hazard;
  assign accept     = in_valid_i && in_ready_o;
  assign busy_o     = (state_q != IDLE) || pipe_busy || w_v_q;
  assign cnt_nx     = cnt_q + 1'b1;
  assign last       = pipe_q[DEPTH-1];
  assign rd_word    = rd_data_i[last.y][last.z];
  sat_add #(.W(DRW)) u_re (.a_i(rd_word[DW-1:DIW]), .b_i(last.re), .s_o(sum_re));
  sat_add #(.W(DIW)) u_im (.a_i(rd_word[DIW-1:0]),  .b_i(last.im), .s_o(sum_im));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      w_v_q        <= 1'b0;
      w_x_q        <= '0;
      w_y_q        <= '0;
      w_z_q        <= '0;
      cnt_q        <= '0;
      rd_addr_o    <= '0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      wren_o       <= '0;
      clear_done_o <= 1'b0;
    end else begin
      pipe_q[0] <= {accept, in_x_i, in_y_i, in_z_i, in_real_i, in_imag_i};
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      if (pipe_q[0].v) rd_addr_o[pipe_q[0].y][pipe_q[0].z] <= pipe_q[0].x;
      w_v_q        <= last.v;
      w_x_q        <= last.x;
      w_y_q        <= last.y;
      w_z_q        <= last.z;
      wren_o       <= '0;
      clear_done_o <= 1'b0;
      if (last.v) begin
        wren_o[last.y][last.z]    <= 1'b1;
        wr_addr_o[last.y][last.z] <= last.x;
        wr_data_o[last.y][last.z] <= {sum_re, sum_im};
      end
      // entering CLEAR only happens with the pipeline empty, so the sweep never collides with a deposit write
      case (state_q)
        IDLE: begin
          if (clear_start_i && !accept) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            wren_o       <= '1;
            wr_addr_o    <= '0;
            wr_data_o    <= '0;
            clear_done_o <= (GAW == 0);
          end else if (clear_start_i) state_q <= DRAIN;
          else if (accept) state_q <= ACCUM;
        end
        ACCUM: begin
          if (clear_start_i) state_q <= DRAIN;
          else if (!pipe_busy && !accept) state_q <= IDLE;
        end
        DRAIN: begin
          if (!pipe_busy) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            wren_o       <= '1;
            wr_addr_o    <= '0;
            wr_data_o    <= '0;
            clear_done_o <= (GAW == 0);
          end
        end
        CLEAR: begin
          if (cnt_q == '1) state_q <= IDLE;
          else begin
            cnt_q        <= cnt_nx;
            wren_o       <= '1;
            wr_addr_o    <= {(D*D){cnt_nx}};
            wr_data_o    <= '0;
            clear_done_o <= (cnt_nx == '1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_grid_accum_ctrl.sv
// tb_grid_accum_ctrl: directed checks of the deposit pipeline and clear sweep against a latency-2 bank memory
module tb_grid_accum_ctrl;
  import grid_accum_ctrl_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, clear_start = 1'b0, clear_done, busy;
  logic [3:0] in_x = '0, in_y = '0, in_z = '0;
  logic [31:0] in_real = '0, in_imag = '0;
  logic [15:0][15:0][3:0]  rd_addr, wr_addr;
  logic [15:0][15:0][63:0] rdd, m1, wr_data;
  logic [15:0][15:0]       wren;
  logic [63:0] mem [16][16][16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_x = '0, pl_y = '0, pl_z = '0;
  logic [63:0] pl_d = '0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  grid_accum_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_x_i(in_x), .in_y_i(in_y), .in_z_i(in_z), .in_real_i(in_real), .in_imag_i(in_imag),
    .clear_start_i(clear_start), .clear_done_o(clear_done), .busy_o(busy),
    .rd_addr_o(rd_addr), .rd_data_i(rdd), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wren_o(wren)
  );
  // bank memory: address registered, data registered again -> two-cycle read latency
  always @(posedge clk) begin
    for (int y = 0; y < 16; y++)
      for (int z = 0; z < 16; z++) begin
        if (wren[y][z]) mem[y][z][wr_addr[y][z]] <= wr_data[y][z];
        m1[y][z]  <= mem[y][z][rd_addr[y][z]];
        rdd[y][z] <= m1[y][z];
      end
    if (pl_en) mem[pl_y][pl_z][pl_x] <= pl_d;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input int x, input int y, input int z, input logic [31:0] re, input logic [31:0] im);
    in_valid = v;
    in_x = x[3:0];
    in_y = y[3:0];
    in_z = z[3:0];
    in_real = re;
    in_imag = im;
    #1;
  endtask
  task automatic preload(input int y, input int z, input int x, input logic [63:0] d);
    pl_en = 1'b1;
    pl_y = y[3:0];
    pl_z = z[3:0];
    pl_x = x[3:0];
    pl_d = d;
    tick;
    pl_en = 1'b0;
  endtask
  task automatic sweep(input int poke);
    for (int a = 0; a < 16; a++) begin
      chk("clr_wren_cnt", 64'($countones(wren)), 64'd256);
      chk("clr_addr_0_0", 64'(wr_addr[0][0]), 64'(a));
      chk("clr_addr_15_7", 64'(wr_addr[15][7]), 64'(a));
      chk("clr_data_zero", 64'(wr_data == '0), 64'd1);
      chk("clr_done", 64'(clear_done), 64'(a == 15));
      chk("clr_ready", 64'(in_ready), 64'd0);
      clear_start = (a == poke);
      tick;
    end
    clear_start = 1'b0;
    chk("clr_end_wren", 64'($countones(wren)), 64'd0);
    chk("clr_end_done", 64'(clear_done), 64'd0);
    chk("clr_end_busy", 64'(busy), 64'd0);
    chk("clr_end_ready", 64'(in_ready), 64'd1);
  endtask
  initial begin
    int nwr;
    #2;
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wren", 64'($countones(wren)), 64'd0);
    chk("rst_done", 64'(clear_done), 64'd0);
    chk("rst_rdaddr", 64'(rd_addr == '0), 64'd1);
    tick;
    rst_n = 1'b1;
    tick;
    chk("idle_ready", 64'(in_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    // clear from IDLE also zeroes the model memory
    clear_start = 1'b1;
    tick;
    sweep(-1);
    // single deposit onto (10,-4)
    preload(1, 2, 3, {32'd10, 32'hFFFF_FFFC});
    drive(1, 3, 1, 2, 32'd5, 32'd7);
    tick;
    drive(0, 0, 0, 0, 0, 0);
    chk("single_busy", 64'(busy), 64'd1);
    tick;
    chk("single_rdaddr", 64'(rd_addr[1][2]), 64'd3);
    tick;
    chk("single_nowr_t2", 64'($countones(wren)), 64'd0);
    tick;
    chk("single_nowr_t3", 64'($countones(wren)), 64'd0);
    tick;
    chk("single_wren", 64'(wren[1][2]), 64'd1);
    chk("single_wrcnt", 64'($countones(wren)), 64'd1);
    chk("single_wraddr", 64'(wr_addr[1][2]), 64'd3);
    chk("single_wrdata", wr_data[1][2], {32'd15, 32'd3});
    tick;
    chk("single_after_wren", 64'($countones(wren)), 64'd0);
    chk("single_after_busy", 64'(busy), 64'd0);
    // same word twice: second must wait for the first write
    drive(1, 5, 0, 0, 32'd1, 32'd1);
    tick;
    chk("haz_ready_t0", 64'(in_ready), 64'd0);
    tick; tick; tick; tick;
    chk("haz_first_wren", 64'(wren[0][0]), 64'd1);
    chk("haz_first_data", wr_data[0][0], {32'd1, 32'd1});
    chk("haz_ready_wrcycle", 64'(in_ready), 64'd0);
    tick;
    chk("haz_ready_release", 64'(in_ready), 64'd1);
    tick;
    drive(0, 0, 0, 0, 0, 0);
    tick; tick; tick; tick;
    chk("haz_second_wren", 64'(wren[0][0]), 64'd1);
    chk("haz_second_data", wr_data[0][0], {32'd2, 32'd2});
    tick;
    chk("haz_mem_final", mem[0][0][5], {32'd2, 32'd2});
    // 16 distinct banks back to back
    for (int i = 0; i < 20; i++) begin
      if (i < 16) begin
        drive(1, i, i, 15 - i, 32'(i), 32'(2 * i));
        chk("burst_ready", 64'(in_ready), 64'd1);
      end else drive(0, 0, 0, 0, 0, 0);
      tick;
      if (i >= 4) begin
        chk("burst_wren", 64'(wren[i-4][19-i]), 64'd1);
        chk("burst_wrcnt", 64'($countones(wren)), 64'd1);
        chk("burst_wraddr", 64'(wr_addr[i-4][19-i]), 64'(i - 4));
        chk("burst_wrdata", wr_data[i-4][19-i], {32'(i - 4), 32'(2 * (i - 4))});
      end
    end
    tick;
    // saturation on both parts
    preload(2, 3, 7, {32'h7FFF_FFF0, 32'h8000_0010});
    drive(1, 7, 2, 3, 32'h0000_0100, 32'hFFFF_FF00);
    tick;
    drive(0, 0, 0, 0, 0, 0);
    tick; tick; tick; tick;
    chk("sat_wren", 64'(wren[2][3]), 64'd1);
    chk("sat_wrdata", wr_data[2][3], {32'h7FFF_FFFF, 32'h8000_0000});
    tick;
    // clear requested with three deposits in flight
    drive(1, 1, 4, 4, 32'd1, 32'd1);
    tick;
    drive(1, 2, 4, 4, 32'd1, 32'd1);
    tick;
    drive(1, 3, 4, 4, 32'd1, 32'd1);
    tick;
    drive(0, 0, 0, 0, 0, 0);
    clear_start = 1'b1;
    tick;
    clear_start = 1'b0;
    chk("drain_ready", 64'(in_ready), 64'd0);
    chk("drain_busy", 64'(busy), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      tick;
      chk("drain_wren", 64'(wren[4][4]), 64'd1);
      chk("drain_wrcnt", 64'($countones(wren)), 64'd1);
      chk("drain_wraddr", 64'(wr_addr[4][4]), 64'(k));
      chk("drain_ready_wr", 64'(in_ready), 64'd0);
    end
    tick;
    sweep(5);
    // reset two cycles after acceptance drops the deposit
    drive(1, 2, 6, 6, 32'd9, 32'd9);
    tick;
    drive(0, 0, 0, 0, 0, 0);
    tick;
    chk("rstmid_rdaddr", 64'(rd_addr[6][6]), 64'd2);
    tick;
    rst_n = 1'b0;
    #1;
    chk("rstmid_wren", 64'($countones(wren)), 64'd0);
    chk("rstmid_rdaddr0", 64'(rd_addr == '0), 64'd1);
    chk("rstmid_wraddr0", 64'(wr_addr == '0), 64'd1);
    chk("rstmid_wrdata0", 64'(wr_data == '0), 64'd1);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_ready", 64'(in_ready), 64'd0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("rstrel_busy", 64'(busy), 64'd0);
    chk("rstrel_ready", 64'(in_ready), 64'd1);
    nwr = 0;
    for (int k = 0; k < 6; k++) begin
      tick;
      nwr += $countones(wren);
    end
    chk("rstrel_nowrite", 64'(nwr), 64'd0);
    chk("rstrel_busy_end", 64'(busy), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
